// File: rtl/bundle_issue_scheduler.sv
// VLIW bundle issue scheduler: a circular queue of {bundle, index} entries drained
// into an output register once the run cycle counter reaches each bundle's index.
module bundle_issue_scheduler #(
   parameter int DEPTH = 8,
   parameter int NSLOT = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [32*NSLOT-1:0]   wr_bundle,
   input  logic [31:0]           wr_index,
   output logic                  full,
   input  logic                  start,
   output logic                  issue_valid,
   input  logic                  issue_ready,
   output logic [32*NSLOT-1:0]   issue_bundle,
   output logic [NSLOT-1:0]      issue_mask,
   output logic                  issue_late,
   output logic [31:0]           cycle,
   output logic [1:0]            state,
   output logic                  err_order
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = 32 * NSLOT;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [BW-1:0]    bundle_mem [DEPTH];
   logic [31:0]      index_mem  [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count, count_d;
   logic [31:0]      last_index;
   logic             first_wr;

   logic [BW-1:0]    head_bundle;
   logic [31:0]      head_index;
   logic [NSLOT-1:0] head_mask;
   logic             order_ok, push, order_err, pop, valid_d;

   // Handshake: issue_valid/issue_* are held stable until issue_ready=1 while
   // issue_valid=1; issue_ready is ignored while issue_valid=0.
   always_comb begin
      head_bundle = bundle_mem[rd_ptr];
      head_index  = index_mem[rd_ptr];
      order_ok    = first_wr || (wr_index >= last_index);
      push        = wr_en && !full && order_ok;
      order_err   = wr_en && !full && !order_ok;
      pop         = (state_q == RUN) && (count != '0) && (head_index <= cycle)
                    && (!issue_valid || issue_ready);
      valid_d     = pop || (issue_valid && !issue_ready);
      count_d     = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   // Mask bit j covers bundle bits [32*j +: 32], i.e. slot NSLOT-1-j.
   always_comb begin
      head_mask = '0;
      for (int j = 0; j < NSLOT; j++) begin
         head_mask[j] = |head_bundle[32*j +: 32];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN:  if ((count_d == '0) && !valid_d) state_d = DONE;
         DONE: if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cycle        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         last_index   <= '0;
         first_wr     <= 1'b1;
         err_order    <= 1'b0;
         issue_valid  <= 1'b0;
         issue_bundle <= '0;
         issue_mask   <= '0;
         issue_late   <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q != RUN) && (state_d == RUN)) begin
            cycle <= '0;
         end else if ((state_q == RUN) && (cycle != 32'hFFFF_FFFF)) begin
            cycle <= cycle + 32'd1;
         end
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_index <= wr_index;
            first_wr   <= 1'b0;
         end
         if (order_err) begin
            err_order <= 1'b1;
         end
         if (pop) begin
            rd_ptr       <= rd_ptr + 1'b1;
            issue_bundle <= head_bundle;
            issue_mask   <= head_mask;
            issue_late   <= (cycle > head_index);
         end
         issue_valid <= valid_d;
         count       <= count_d;
      end
   end

   // Storage has no reset; entries only become visible through the pointers.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         bundle_mem[wr_ptr] <= wr_bundle;
         index_mem[wr_ptr]  <= wr_index;
      end
   end

   assign full  = (count == FULL_CNT);
   assign state = state_q;

endmodule

// File: tb/tb_bundle_issue_scheduler.sv
// Bench for bundle_issue_scheduler: directed schedule scenarios plus randomized
// runs, checked by a scoreboard of accepted bundles popped at each handshake.
module tb_bundle_issue_scheduler;

   localparam int DEPTH = 8;
   localparam int NSLOT = 10;
   localparam int W     = 32 * NSLOT;

   logic             clk = 1'b0;
   logic             rst, wr_en, start, issue_ready;
   logic [W-1:0]     wr_bundle, issue_bundle;
   logic [31:0]      wr_index, cycle;
   logic             full, issue_valid, issue_late, err_order;
   logic [NSLOT-1:0] issue_mask;
   logic [1:0]       state;

   always #5 clk = ~clk;

   bundle_issue_scheduler #(.DEPTH(DEPTH), .NSLOT(NSLOT)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bundle(wr_bundle), .wr_index(wr_index),
      .full(full), .start(start), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_bundle(issue_bundle), .issue_mask(issue_mask), .issue_late(issue_late),
      .cycle(cycle), .state(state), .err_order(err_order)
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [W-1:0] exp_q[$];
   logic [31:0] idx_q[$];
   int          pres_log[$];
   int          hs_log[$];
   int          n_acc, n_hs;
   logic [31:0] last_m;
   bit          have_last, err_m;
   int          tb_cyc = 0;
   bit          holding = 1'b0;
   bit          cur_late = 1'b0;
   bit          rand_ready = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [NSLOT-1:0] exp_mask(input logic [W-1:0] b);
      logic [NSLOT-1:0] m;
      logic [31:0]      s;
      m = '0;
      for (int k = 0; k < NSLOT; k++) begin
         s = b[W-1-32*k -: 32];
         m[NSLOT-1-k] = (s != 32'd0);
      end
      return m;
   endfunction

   function automatic logic [W-1:0] rand_bundle();
      logic [W-1:0] b;
      b = '0;
      for (int k = 0; k < NSLOT; k++) begin
         if ($urandom_range(0, 2) != 0) b[32*k +: 32] = $urandom;
      end
      return b;
   endfunction

   // Run-relative cycle as the bench sees it: zero on the start edge.
   always @(posedge clk) begin
      if (rst || start) tb_cyc <= 0;
      else              tb_cyc <= tb_cyc + 1;
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_ready) issue_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compares every presented bundle against the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         holding = 1'b0;
      end else if (issue_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_issue: got bundle %0h, expected no pending bundle", issue_bundle);
         end else begin
            if (!holding) begin
               holding  = 1'b1;
               pres_log.push_back(tb_cyc);
               cur_late = (tb_cyc > idx_q[0] + 1);
            end
            check("issue_bundle", issue_bundle, exp_q[0]);
            check("issue_mask", issue_mask, exp_mask(exp_q[0]));
            check("issue_late", issue_late, cur_late);
            check("issue_cycle", cycle, tb_cyc);
            check("not_early", (tb_cyc >= idx_q[0] + 1), 1);
            if (issue_ready) begin
               hs_log.push_back(tb_cyc);
               void'(exp_q.pop_front());
               void'(idx_q.pop_front());
               n_hs++;
               holding = 1'b0;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_model();
      exp_q.delete();
      idx_q.delete();
      pres_log.delete();
      hs_log.delete();
      n_acc = 0;
      n_hs = 0;
      last_m = 0;
      have_last = 1'b0;
      err_m = 1'b0;
   endtask

   task automatic check_reset_state();
      check("rst_state", state, 2'd0);
      check("rst_cycle", cycle, 0);
      check("rst_full", full, 0);
      check("rst_valid", issue_valid, 0);
      check("rst_bundle", issue_bundle, 0);
      check("rst_mask", issue_mask, 0);
      check("rst_late", issue_late, 0);
      check("rst_err", err_order, 0);
   endtask

   task automatic do_reset();
      rand_ready = 1'b0;
      rst = 1'b1;
      wr_en = 1'b0;
      start = 1'b0;
      issue_ready = 1'b0;
      tick(2);
      rst = 1'b0;
      reset_model();
      check_reset_state();
   endtask

   // Acceptance model: room in the queue and a non-decreasing index.
   task automatic wr(input logic [W-1:0] b, input logic [31:0] idx);
      bit full_m, ok;
      full_m = ((n_acc - n_hs) >= DEPTH);
      ok     = !have_last || (idx >= last_m);
      if (!full_m && ok) begin
         exp_q.push_back(b);
         idx_q.push_back(idx);
         last_m = idx;
         have_last = 1'b1;
         n_acc++;
      end else if (!full_m) begin
         err_m = 1'b1;
      end
      wr_en = 1'b1;
      wr_bundle = b;
      wr_index = idx;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_room();
      int t;
      t = 0;
      while (((n_acc - n_hs) >= DEPTH) && (t < 500)) begin
         tick();
         t++;
      end
      if ((n_acc - n_hs) >= DEPTH) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_room: got %0d outstanding, expected below %0d", n_acc - n_hs, DEPTH);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int t;
      t = 0;
      while ((state != 2'd2) && (t < budget)) begin
         tick();
         t++;
      end
      if (state != 2'd2) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_done: got state %0d, expected 2 within %0d cycles", state, budget);
      end
   endtask

   task automatic finish_run();
      wait_done(2000);
      for (int tries = 0; tries < 4; tries++) begin
         if (exp_q.size() != 0) begin
            pulse_start();
            wait_done(2000);
         end
      end
   endtask

   function automatic logic [31:0] next_idx();
      if (have_last && (last_m > 0) && ($urandom_range(0, 5) == 0)) return last_m - 1;
      return last_m + $urandom_range(0, 4);
   endfunction

   initial begin
      int t1_exp[6];
      int t1_idx[6];
      int nw, t;
      logic [W-1:0] b;
      t1_exp = '{1, 9, 27, 35, 43, 51};
      t1_idx = '{0, 8, 26, 34, 42, 50};
      rst = 1'b1; wr_en = 1'b0; start = 1'b0; issue_ready = 1'b0;
      wr_bundle = '0; wr_index = '0;

      // Basic schedule
      do_reset();
      for (int i = 0; i < 6; i++) wr(rand_bundle(), t1_idx[i]);
      pulse_start();
      issue_ready = 1'b1;
      wait_done(200);
      check("t1_done_cycle", cycle, 52);
      check("t1_hs_count", hs_log.size(), 6);
      for (int i = 0; i < hs_log.size() && i < 6; i++) check("t1_hs_cycle", hs_log[i], t1_exp[i]);

      // Back-pressure
      do_reset();
      wr(rand_bundle(), 0);
      wr(rand_bundle(), 1);
      pulse_start();
      t = 0;
      while ((tb_cyc < 5) && (t < 20)) begin tick(); t++; end
      issue_ready = 1'b1;
      wait_done(50);
      check("t2_pres_count", pres_log.size(), 2);
      check("t2_hs_count", hs_log.size(), 2);
      if (pres_log.size() == 2 && hs_log.size() == 2) begin
         check("t2_pres0", pres_log[0], 1);
         check("t2_hs0", hs_log[0], 5);
         check("t2_pres1", pres_log[1], 6);
      end

      // Full and pointer wrap
      do_reset();
      for (int i = 0; i < 9; i++) begin
         wr(rand_bundle(), 10 * i);
         if (i == 7) check("t3_full_after_8", full, 1);
      end
      check("t3_full_after_9", full, 1);
      check("t3_err", err_order, err_m);
      pulse_start();
      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_room();
         wr(rand_bundle(), 90 + i);
      end
      finish_run();
      check("t3_issued", hs_log.size(), 16);

      // Ordering error
      do_reset();
      wr(rand_bundle(), 20);
      wr(rand_bundle(), 10);
      check("t4_err_set", err_order, err_m);
      wr(rand_bundle(), 20);
      pulse_start();
      issue_ready = 1'b1;
      finish_run();
      check("t4_issued", hs_log.size(), 2);
      if (pres_log.size() == 2) begin
         check("t4_pres0", pres_log[0], 21);
         check("t4_pres1", pres_log[1], 22);
      end

      // Mask, then reset in the middle of a run
      do_reset();
      b = '0;
      b[W-1 -: 32] = $urandom | 32'd1;
      b[W-1-32*8 -: 32] = 32'h00A5_0000;
      wr(b, 0);
      wr(rand_bundle(), 100);
      wr(rand_bundle(), 101);
      wr(rand_bundle(), 102);
      pulse_start();
      issue_ready = 1'b1;
      tick();
      check("t5_valid", issue_valid, 1);
      check("t5_mask", issue_mask, 10'b1000000010);
      t = 0;
      while ((tb_cyc < 5) && (t < 20)) begin tick(); t++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      reset_model();
      check_reset_state();
      pulse_start();
      wait_done(10);
      check("t5_no_stale_issue", hs_log.size(), 0);

      // Randomized runs
      for (int r = 0; r < 8; r++) begin
         do_reset();
         rand_ready = 1'b1;
         nw = $urandom_range(1, DEPTH + 2);
         for (int i = 0; i < nw; i++) wr(rand_bundle(), next_idx());
         check("rnd_err_idle", err_order, err_m);
         pulse_start();
         nw = $urandom_range(0, 12);
         for (int i = 0; i < nw; i++) begin
            tick($urandom_range(0, 3));
            wait_room();
            wr(rand_bundle(), next_idx());
         end
         finish_run();
         check("rnd_all_issued", exp_q.size(), 0);
         check("rnd_issued_count", hs_log.size(), n_acc);
         check("rnd_err", err_order, err_m);
         check("rnd_full_end", full, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no end of test, expected completion before 2 ms");
      $fatal(1, "global timeout");
   end

endmodule
